// File: rtl/iob_cache_be_arb_pkg.sv
// Shared types and helpers for the cache back-end arbiter.
package iob_cache_be_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

  localparam logic [1:0] GNT_W = 2'b01;
  localparam logic [1:0] GNT_R = 2'b10;

  // Counter holds values 0..max(N)-1 and the length N itself.
  function automatic int beat_cnt_w(input int wr_beats, input int rd_beats);
    int m;
    m = (wr_beats > rd_beats) ? wr_beats : rd_beats;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/iob_cache_burst_counter.sv
// Beat counter for one back-end burst; flags the final beat and self-clears on it.
module iob_cache_burst_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  input  logic [W-1:0] len,
  output logic         last
);

  logic [W-1:0] cnt_q, cnt_d;

  assign last = (cnt_q == len - W'(1));

  always_comb begin
    cnt_d = cnt_q;
    if (en) cnt_d = last ? '0 : cnt_q + W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/iob_cache_be_arbiter.sv
// Shares the native back-end port between the cache write and read channels,
// holding each grant for a full burst. Define IOB_CACHE_BE_ARB_RR_EN for round-robin.
module iob_cache_be_arbiter
  import iob_cache_be_arb_pkg::*;
#(
  parameter int BE_ADDR_W = 32,
  parameter int BE_DATA_W = 32,
  parameter int WR_BEATS  = 1,
  parameter int RD_BEATS  = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   w_valid,
  input  logic [BE_ADDR_W-1:0]   w_addr,
  input  logic [BE_DATA_W-1:0]   w_wdata,
  input  logic [BE_DATA_W/8-1:0] w_wstrb,
  output logic                   w_ready,
  input  logic                   r_valid,
  input  logic [BE_ADDR_W-1:0]   r_addr,
  output logic [BE_DATA_W-1:0]   r_rdata,
  output logic                   r_ready,
  output logic                   be_valid,
  output logic [BE_ADDR_W-1:0]   be_addr,
  output logic [BE_DATA_W-1:0]   be_wdata,
  output logic [BE_DATA_W/8-1:0] be_wstrb,
  input  logic [BE_DATA_W-1:0]   be_rdata,
  input  logic                   be_ready,
  output logic                   busy,
  output logic [1:0]             grant
);

  localparam int               CNT_W  = beat_cnt_w(WR_BEATS, RD_BEATS);
  localparam logic [CNT_W-1:0] WR_LEN = CNT_W'(WR_BEATS);
  localparam logic [CNT_W-1:0] RD_LEN = CNT_W'(RD_BEATS);

  state_t           state_q, state_d;
  logic             beat, last, wr_sel;
  logic [CNT_W-1:0] len;

`ifdef IOB_CACHE_BE_ARB_RR_EN
  // 1 = read was granted most recently; resets to read so first contention goes to write.
  logic last_grant_q;

  assign wr_sel = w_valid & (~r_valid | last_grant_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                last_grant_q <= 1'b1;
    else if (state_q == IDLE && (w_valid | r_valid)) last_grant_q <= ~wr_sel;
  end
`else
  // Write always wins so a fill can never overtake pending write data.
  assign wr_sel = w_valid;
`endif

  assign len  = (state_q == WRITE) ? WR_LEN : RD_LEN;
  assign beat = be_valid & be_ready;

  iob_cache_burst_counter #(.W(CNT_W)) u_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (beat),
    .len     (len),
    .last    (last)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (wr_sel)       state_d = WRITE;
        else if (r_valid) state_d = READ;
      end
      WRITE, READ: if (beat && last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    be_valid = 1'b0;
    be_addr  = '0;
    be_wdata = '0;
    be_wstrb = '0;
    w_ready  = 1'b0;
    r_ready  = 1'b0;
    grant    = 2'b00;
    unique case (state_q)
      WRITE: begin
        be_valid = w_valid;
        be_addr  = w_addr;
        be_wdata = w_wdata;
        be_wstrb = w_wstrb;
        w_ready  = be_ready;
        grant    = GNT_W;
      end
      READ: begin
        be_valid = r_valid;
        be_addr  = r_addr;
        r_ready  = be_ready;
        grant    = GNT_R;
      end
      default: ;
    endcase
  end

  assign busy    = (state_q != IDLE);
  assign r_rdata = be_rdata;

endmodule

// File: tb/tb_iob_cache_be_arbiter.sv
// Scoreboard bench for the back-end arbiter: expected beats are queued as driven
// and checked when the back-end handshake completes.
module tb_iob_cache_be_arbiter;

  localparam logic [1:0] GW = 2'b01;
  localparam logic [1:0] GR = 2'b10;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        w_valid, w_ready, r_valid, r_ready;
  logic [31:0] w_addr, w_wdata, r_addr, r_rdata;
  logic [3:0]  w_wstrb, be_wstrb;
  logic        be_valid, be_ready, busy;
  logic [31:0] be_addr, be_wdata, be_rdata;
  logic [1:0]  grant;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] rdata;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    wr_cnt = 0;
  int    rd_cnt = 0;
  bit    last_rd = 1'b1;

  iob_cache_be_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .w_valid(w_valid), .w_addr(w_addr), .w_wdata(w_wdata), .w_wstrb(w_wstrb), .w_ready(w_ready),
    .r_valid(r_valid), .r_addr(r_addr), .r_rdata(r_rdata), .r_ready(r_ready),
    .be_valid(be_valid), .be_addr(be_addr), .be_wdata(be_wdata), .be_wstrb(be_wstrb),
    .be_rdata(be_rdata), .be_ready(be_ready), .busy(busy), .grant(grant)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Beats are only checked on a real handshake; ready pulses are counted raw.
  always @(negedge clk) begin
    if (reset_n) begin
      if (w_ready) wr_cnt++;
      if (r_ready) rd_cnt++;
      if (be_valid && be_ready) begin
        if (exp_q.size() == 0) chk("beat_unexpected", 1, 0);
        else begin
          beat_t e;
          e = exp_q.pop_front();
          chk("be_addr", be_addr, e.addr);
          chk("be_wdata", be_wdata, e.data);
          chk("be_wstrb", be_wstrb, e.strb);
          chk("w_ready", w_ready, e.wr);
          chk("r_ready", r_ready, !e.wr);
          if (!e.wr) chk("r_rdata", r_rdata, e.rdata);
        end
      end
    end
  end

  function automatic logic [1:0] contend_gnt();
`ifdef IOB_CACHE_BE_ARB_RR_EN
    return last_rd ? GW : GR;
`else
    return GW;
`endif
  endfunction

  task automatic req(input bit w, input bit r, input logic [1:0] g);
    if (w) w_valid = 1'b1;
    if (r) r_valid = 1'b1;
    #1 chk("idle_busy", busy, 0);
    tick();
    chk("grant", grant, g);
    last_rd = (g == GR);
  endtask

  // Runs beats [first,lim) of a granted burst. Gap cycles either stall on
  // be_ready (gap_drop=0) or drop the requester valid while be_ready=1.
  task automatic run_burst(input bit wr, input logic [31:0] base, input int first,
                           input int lim, input int gap, input bit gap_drop, input bit fin);
    logic [1:0] g;
    beat_t e;
    g = wr ? GW : GR;
    for (int i = first; i < lim; i++) begin
      for (int k = 0; k < gap; k++) begin
        be_ready = gap_drop;
        if (gap_drop) begin
          if (wr) w_valid = 1'b0; else r_valid = 1'b0;
        end
        #1 chk("hold_grant", grant, g);
        if (gap_drop) chk("drop_be_valid", be_valid, 0);
        if (!wr) chk("w_blocked", w_ready, 0);
        tick();
      end
      e.wr    = wr;
      e.addr  = base + 32'(4 * i);
      e.data  = wr ? $urandom : 32'h0;
      e.strb  = wr ? 4'hF : 4'h0;
      e.rdata = $urandom;
      if (wr) begin
        w_valid = 1'b1; w_addr = e.addr; w_wdata = e.data; w_wstrb = e.strb;
      end else begin
        r_valid = 1'b1; r_addr = e.addr;
      end
      be_rdata = e.rdata;
      be_ready = 1'b1;
      exp_q.push_back(e);
      #1 chk("beat_grant", grant, g);
      chk("beat_be_valid", be_valid, 1);
      if (!wr) chk("rd_wstrb", be_wstrb, 0);
      if (!wr) chk("w_blocked", w_ready, 0);
      tick();
    end
    be_ready = 1'b0;
    if (fin) begin
      if (wr) w_valid = 1'b0; else r_valid = 1'b0;
    end
  endtask

  task automatic contend(input logic [31:0] wa, input logic [31:0] ra);
    logic [1:0] g;
    g = contend_gnt();
    req(1, 1, g);
    if (g == GW) begin
      run_burst(1, wa, 0, 1, 0, 0, 1);
      req(0, 1, GR);
      run_burst(0, ra, 0, 4, 0, 0, 1);
    end else begin
      run_burst(0, ra, 0, 4, 0, 0, 1);
      req(1, 0, GW);
      run_burst(1, wa, 0, 1, 0, 0, 1);
    end
  endtask

  initial begin
    reset_n = 1'b0; w_valid = 1'b1; r_valid = 1'b0; be_ready = 1'b1;
    w_addr = 32'h100; w_wdata = 32'hCAFE0001; w_wstrb = 4'hF;
    r_addr = 32'h0; be_rdata = 32'h0;
    repeat (3) tick();
    chk("rst_be_valid", be_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant, 0);
    chk("rst_w_ready", w_ready, 0);
    chk("rst_wstrb", be_wstrb, 0);

    // Release with write pending: granted one cycle later, beat on second WRITE cycle.
    be_ready = 1'b0;
    reset_n  = 1'b1;
    #1 chk("rel_idle", busy, 0);
    tick();
    chk("rel_grant", grant, GW);
    chk("rel_be_valid", be_valid, 1);
    last_rd = 1'b0;
    wr_cnt = 0;
    run_burst(1, 32'h100, 0, 1, 1, 0, 1);
    #1 chk("wt_idle", busy, 0);
    chk("wt_pulses", wr_cnt, 1);

    // Line fill with be_ready every other cycle.
    rd_cnt = 0;
    req(0, 1, GR);
    run_burst(0, 32'h200, 0, 4, 1, 0, 1);
    #1 chk("fill_idle", busy, 0);
    chk("fill_pulses", rd_cnt, 4);

    contend(32'h700, 32'h800);
    req(1, 0, GW);
    run_burst(1, 32'h900, 0, 1, 0, 0, 1);
    contend(32'hA00, 32'hB00);

    // Hold: write arrives mid-fill; also a requester valid drop with stray be_ready.
    req(0, 1, GR);
    run_burst(0, 32'h300, 0, 2, 0, 0, 0);
    w_valid = 1'b1; w_addr = 32'h400;
    run_burst(0, 32'h300, 2, 4, 1, 1, 1);
    #1 chk("hold_bubble", grant, 0);
    tick();
    chk("hold_wr_grant", grant, GW);
    last_rd = 1'b0;
    run_burst(1, 32'h400, 0, 1, 0, 0, 1);

    // Reset mid-burst abandons the fill; the next fill needs all 4 beats.
    req(0, 1, GR);
    run_burst(0, 32'h500, 0, 2, 0, 0, 0);
    r_valid = 1'b1; be_ready = 1'b1;
    reset_n = 1'b0;
    #1 chk("mid_rst_be_valid", be_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_r_ready", r_ready, 0);
    r_valid = 1'b0; be_ready = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    last_rd = 1'b1;
    req(0, 1, GR);
    run_burst(0, 32'h600, 0, 4, 0, 0, 1);
    #1 chk("restart_idle", busy, 0);

    tick();
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/iob_cache_be_arbiter.md
Name: iob_cache_be_arbiter

Overview:
- Shares the cache's single native back-end memory port between two requesters:
  - the write channel (write-through word writes or write-back line evictions);
  - the read channel (line fills).
- Grants one requester at a time and holds the grant for a full burst of a fixed beat count, then re-arbitrates.
- Sits between the cache write/read channels and the external memory interface.

Parameters:
- BE_ADDR_W, 32, back-end byte address width.
- BE_DATA_W, 32, back-end data width; must be a multiple of 8.
- WR_BEATS, 1, beats per write transaction: 1 for write-through, line words / back-end words for write-back.
- RD_BEATS, 4, beats per read (line fill) transaction; must be >= 1.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- w_valid  in  1  write-channel request
- w_addr  in  BE_ADDR_W  write address
- w_wdata  in  BE_DATA_W  write data
- w_wstrb  in  BE_DATA_W/8  write byte strobes
- w_ready  out  1  write beat accepted
- r_valid  in  1  read-channel request
- r_addr  in  BE_ADDR_W  read address
- r_rdata  out  BE_DATA_W  read data, equal to be_rdata
- r_ready  out  1  read beat returned
- be_valid  out  1  back-end request
- be_addr  out  BE_ADDR_W  back-end address
- be_wdata  out  BE_DATA_W  back-end write data
- be_wstrb  out  BE_DATA_W/8  back-end strobes; all zero means read
- be_rdata  in  BE_DATA_W  back-end read data
- be_ready  in  1  back-end beat done
- busy  out  1  state != IDLE
- grant  out  2  one-hot {read, write}

Behaviour:
- Registers: state (IDLE/WRITE/READ) and beat counter, width clog2(max(WR_BEATS,RD_BEATS))+1.
- Reset (asynchronous, takes effect immediately):
  - state=IDLE, counter=0.
  - All outputs derive combinationally from state, so be_valid, be_wstrb, w_ready, r_ready, busy and grant are 0 while reset_n=0.
- IDLE:
  - be_* outputs = 0, ready outputs = 0.
  - Next state: w_valid -> WRITE; else r_valid -> READ; else stay IDLE.
  - Grant latency: 1 cycle from request to be_valid.
- WRITE:
  - be_valid=w_valid, be_addr=w_addr, be_wdata=w_wdata, be_wstrb=w_wstrb.
  - w_ready=be_ready, r_ready=0.
- READ:
  - be_valid=r_valid, be_addr=r_addr, be_wdata=0, be_wstrb=0.
  - r_ready=be_ready, w_ready=0.
- Beat counting:
  - A beat is be_valid & be_ready; counter increments on each beat.
  - On the beat where counter==N-1 (N=WR_BEATS or RD_BEATS): counter<=0, state<=IDLE.
  - Result: one idle bubble cycle between consecutive transactions.
- be_ready while be_valid=0: ignored, no count.
- Requester drops valid mid-burst: grant is held, and be_valid follows the requester's valid. The other requester stays blocked until the remaining beats complete.
- Simultaneous w_valid and r_valid in IDLE: write wins (default policy). This guarantees a read never overtakes pending write data.
- r_rdata = be_rdata at all times; it is valid only when r_ready=1.
- Counter wrap: only ever reaches N-1, never overflows.
- Reset mid-burst: the partial burst is abandoned and no further beats are issued. Requesters are reset by the same reset_n.

Optional Feature:
- Macro: IOB_CACHE_BE_ARB_RR_EN.
- Defined:
  - Adds a 1-bit last_grant register; reset value = READ, so the first contention goes to write.
  - When both requests are present in IDLE, grant goes to the requester not served last.
  - A single pending requester is always granted.
- Undefined: fixed write-over-read priority, and no last_grant register exists.

Decomposition:
- Package iob_cache_be_arb_pkg:
  - state localparams IDLE=2'd0, WRITE=2'd1, READ=2'd2;
  - grant encodings GNT_W=2'b01, GNT_R=2'b10;
  - the beat-counter width function.
- Sub-module iob_cache_burst_counter:
  - inputs: clk, reset_n, en (beat), len (N);
  - output: last (counter==N-1);
  - self-clears on en & last.
- Arbiter top holds the FSM and the output mux.

Test Plan:
- Reset: reset_n=0 with w_valid=1 -> be_valid=0, busy=0, grant=00; after release, be_valid=1 with grant=01 one cycle later.
- Write-through (WR_BEATS=1): w_valid, w_addr=0x100, w_wstrb=4'hF, be_ready on the second cycle of WRITE -> one beat, w_ready pulses once, IDLE next cycle.
- Line fill (RD_BEATS=4): r_addr 0x200..0x20C, be_ready every other cycle -> r_ready pulses exactly 4 times, be_wstrb=0 throughout, then IDLE.
- Contention: w_valid and r_valid rise in the same cycle -> WRITE first; READ granted after write completion plus one bubble. With IOB_CACHE_BE_ARB_RR_EN, a repeat contention grants READ first.
- Hold: during READ with 2 of 4 beats done, w_valid rises -> w_ready stays 0 until the 4th beat, then WRITE after one IDLE cycle.
- Reset mid-burst: reset_n low after beat 2 of 4 -> be_valid=0 immediately; after release, a new r_valid restarts the count at 0 and needs 4 full beats.
